// File: rtl/ps2_rx_fifo.sv
// Keyboard type-ahead FIFO between the PS/2 ASCII decoder and a two-register CPU bus port.
// Optional interrupt output and enable bit: define PS2_FIFO_IRQ_EN.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] in_data,
  input  logic       in_valid
`ifdef PS2_FIFO_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   L_DEPTH   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   L_HALF    = (DEPTH_LOG2 + 1)'(DEPTH / 2);
  localparam logic [DEPTH_LOG2:0]   L_CNT_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] L_PTR_ONE = (DEPTH_LOG2)'(1);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovfl;
  logic [7:0]            r_dout;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_half;
  logic                  w_rd_data;
  logic                  w_rd_stat;
  logic                  w_ctrl_wr;
  logic                  w_flush;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_reject;
  logic                  w_ien;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic [7:0]            w_status;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == L_DEPTH);
  assign w_half    = (r_count >= L_HALF);
  assign w_rd_data = cs & ~we & addr;
  assign w_rd_stat = cs & ~we & ~addr;
  assign w_ctrl_wr = cs & we & ~addr;
  assign w_flush   = w_ctrl_wr & din[0];
  assign w_pop     = w_rd_data & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_push    = in_valid & ~w_flush & (~w_full | w_pop);
  assign w_reject  = in_valid & ~w_flush & w_full & ~w_pop;
  assign w_status  = {3'b000, w_ien, w_half, w_full, r_ovfl, ~w_empty};

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush)
      w_count_nxt = '0;
    else if (w_push && !w_pop)
      w_count_nxt = r_count + L_CNT_ONE;
    else if (w_pop && !w_push)
      w_count_nxt = r_count - L_CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovfl  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_ovfl <= 1'b0;
      end else begin
        if (w_push)   r_wptr <= r_wptr + L_PTR_ONE;
        if (w_pop)    r_rptr <= r_rptr + L_PTR_ONE;
        if (w_reject) r_ovfl <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_dout <= 8'h00;
    else if (w_rd_data)
      r_dout <= w_empty ? 8'h00 : r_mem[r_rptr];
    else if (w_rd_stat)
      r_dout <= w_status;
  end

  assign dout = r_dout;

`ifdef PS2_FIFO_IRQ_EN
  logic r_ien;
  logic w_ien_nxt;
  logic w_unused;

  assign w_ien_nxt = w_ctrl_wr ? din[1] : r_ien;
  assign w_ien     = r_ien;
  assign w_unused  = ^din[7:2];

  // irq tracks the post-edge state so it rises with the first landed byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ien <= 1'b0;
      irq   <= 1'b0;
    end else begin
      r_ien <= w_ien_nxt;
      irq   <= w_ien_nxt & (w_count_nxt != '0);
    end
  end
`else
  logic w_unused;

  assign w_ien    = 1'b0;
  assign w_unused = ^din[7:1];
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: queue-based model compared every cycle plus directed literal checks.
// Covers the irq path when built with PS2_FIFO_IRQ_EN.
module tb_ps2_rx_fifo;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
`ifdef PS2_FIFO_IRQ_EN
  logic       irq;
`endif

  int n_total = 0;
  int n_pass  = 0;

  ps2_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
    .in_data(in_data), .in_valid(in_valid)
`ifdef PS2_FIFO_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a byte queue plus flags, advanced once per rising edge.
  logic [7:0] m_q[$];
  logic       m_ovfl = 1'b0;
  logic       m_ien  = 1'b0;
  logic [7:0] m_dout = 8'h00;
  logic       m_irq  = 1'b0;

  always @(posedge clk) begin
    int  pre;
    bit  popped;
    logic [7:0] s_din, s_in;
    bit s_cs, s_we, s_addr, s_valid;
    s_cs = cs; s_we = we; s_addr = addr; s_din = din; s_in = in_data; s_valid = in_valid;
    if (rst) begin
      m_q.delete();
      m_ovfl = 1'b0;
      m_ien  = 1'b0;
      m_dout = 8'h00;
    end else begin
      pre = m_q.size();
      popped = 1'b0;
      if (s_cs && !s_we && !s_addr)
        m_dout = {3'b000, m_ien, pre >= DEPTH / 2, pre == DEPTH, m_ovfl, pre != 0};
      if (s_cs && !s_we && s_addr) begin
        if (pre > 0) begin
          m_dout = m_q.pop_front();
          popped = 1'b1;
        end else m_dout = 8'h00;
      end
      if (s_cs && s_we && !s_addr && s_din[0]) begin
        m_q.delete();
        m_ovfl = 1'b0;
      end else if (s_valid) begin
        if (pre < DEPTH || popped) m_q.push_back(s_in);
        else m_ovfl = 1'b1;
      end
`ifdef PS2_FIFO_IRQ_EN
      if (s_cs && s_we && !s_addr) m_ien = s_din[1];
`endif
    end
    m_irq = m_ien && (m_q.size() != 0);
    #1;
    check("dout_vs_model", dout, m_dout);
`ifdef PS2_FIFO_IRQ_EN
    check("irq_vs_model", {7'b0, irq}, {7'b0, m_irq});
`endif
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic a, output logic [7:0] v);
    cs = 1'b1; we = 1'b0; addr = a;
    step();
    cs = 1'b0;
    v = dout;
  endtask

  task automatic rd_push(input logic [7:0] b, output logic [7:0] v);
    cs = 1'b1; we = 1'b0; addr = 1'b1; in_valid = 1'b1; in_data = b;
    step();
    cs = 1'b0; in_valid = 1'b0;
    v = dout;
  endtask

  task automatic wr(input logic [7:0] d, input logic do_push, input logic [7:0] b);
    cs = 1'b1; we = 1'b1; addr = 1'b0; din = d; in_valid = do_push; in_data = b;
    step();
    cs = 1'b0; we = 1'b0; in_valid = 1'b0; din = 8'h00;
  endtask

  initial begin
    logic [7:0] v;
    repeat (3) step();
    rst = 1'b0;
    check("reset_dout", dout, 8'h00);
    rd(1'b0, v); check("reset_status", v, 8'h00);
    rd(1'b1, v); check("empty_read", v, 8'h00);
    rd(1'b0, v); check("empty_read_status", v, 8'h00);

    push(8'h41); push(8'h42); push(8'h43);
    rd(1'b0, v); check("status_three", v, 8'h01);
    rd(1'b1, v); check("read_41", v, 8'h41);
    rd(1'b1, v); check("read_42", v, 8'h42);
    rd(1'b1, v); check("read_43", v, 8'h43);
    rd(1'b0, v); check("status_drained", v, 8'h00);

    for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
    rd(1'b0, v); check("status_overflow", v, 8'h0F);
    for (int i = 0; i < 16; i++) begin
      rd(1'b1, v); check("overflow_drain", v, 8'h30 + 8'(i));
    end
    rd(1'b0, v); check("status_ovfl_sticky", v, 8'h02);
    wr(8'h01, 1'b0, 8'h00);
    rd(1'b0, v); check("status_after_flush", v, 8'h00);

    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
    rd_push(8'h55, v); check("full_pop_push_oldest", v, 8'h60);
    rd(1'b0, v); check("full_pop_push_status", v, 8'h0D);
    for (int i = 1; i < 16; i++) begin
      rd(1'b1, v); check("full_drain", v, 8'h60 + 8'(i));
    end
    rd(1'b1, v); check("full_drain_last_55", v, 8'h55);
    rd(1'b0, v); check("status_after_drain", v, 8'h00);

    rd_push(8'hA5, v); check("empty_read_with_push", v, 8'h00);
    rd(1'b0, v); check("status_kept_byte", v, 8'h01);
    rd(1'b1, v); check("kept_byte", v, 8'hA5);

    for (int i = 0; i < 40; i++) begin
      push(8'h80 + 8'(i));
      if (i >= 2) begin
        rd(1'b1, v); check("wrap_order", v, 8'h80 + 8'(i - 2));
      end
    end
    rd(1'b1, v); check("wrap_tail0", v, 8'h80 + 8'd38);
    rd(1'b1, v); check("wrap_tail1", v, 8'h80 + 8'd39);

    for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i));
    wr(8'h01, 1'b1, 8'h99);
    rd(1'b0, v); check("flush_concurrent_status", v, 8'h00);
    rd(1'b1, v); check("flush_concurrent_discard", v, 8'h00);

    push(8'h11); push(8'h12);
    rst = 1'b1; step(); rst = 1'b0;
    rd(1'b0, v); check("midstream_reset_status", v, 8'h00);

`ifdef PS2_FIFO_IRQ_EN
    wr(8'h02, 1'b0, 8'h00);
    check("irq_idle", {7'b0, irq}, 8'h00);
    rd(1'b0, v); check("status_ien", v, 8'h10);
    push(8'h77);
    check("irq_assert", {7'b0, irq}, 8'h01);
    rd(1'b1, v); check("irq_byte", v, 8'h77);
    check("irq_deassert", {7'b0, irq}, 8'h00);
    wr(8'h03, 1'b0, 8'h00);
    rd(1'b0, v); check("flush_sets_ien", v, 8'h10);
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
